ram_nc_burst_initiator: RTL and testbench
=========================================

Name: ram_nc_burst_initiator

Overview:
- Initiator-side sequencer that drives a single-port, no-change-mode synchronous RAM port (en, we, address, din in; dout out, 1-cycle read latency, dout held on writes).
- Accepts burst commands from an upstream client over valid/ready and streams write data in and read data out over valid/ready.
- Sits between a client and the RAM, converting bursts into per-cycle RAM accesses.
- Handles read latency and downstream backpressure with a 2-entry response buffer.

Parameters:
- addressWidth, 5, RAM address width; depth 2**addressWidth.
- dataWidth, 32, data width.
- lenWidth, 4, burst length field width; burst = cmd_len+1 beats (1..2**lenWidth).

Ports:
- clk  in  1  Single clock, all logic on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- cmd_valid  in  1  Command request.
- cmd_ready  out  1  High only in IDLE.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  addressWidth  Start address.
- cmd_len  in  lenWidth  Beats minus one.
- wdata_valid  in  1  Write beat valid.
- wdata_ready  out  1  High only in WRITE.
- wdata  in  dataWidth  Write beat data.
- rdata_valid  out  1  Read beat valid (buffer non-empty).
- rdata_ready  in  1  Downstream accept.
- rdata  out  dataWidth  Read beat data (buffer head).
- rdata_last  out  1  Marks final beat of the read burst.
- busy  out  1  High whenever the state is not IDLE.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_address  out  addressWidth  RAM address.
- ram_din  out  dataWidth  RAM write data.
- ram_dout  in  dataWidth  RAM read data, valid the cycle after a read issue.

Behaviour:
- Reset (async, immediate):
  - State IDLE; address/beat counters 0; in-flight flag 0; response buffer emptied.
  - Outputs: cmd_ready=1, wdata_ready=0, rdata_valid=0, rdata_last=0, busy=0, ram_en=0, ram_we=0, ram_address=0, ram_din=0.
  - Reset mid-burst abandons the burst and drops any in-flight read. No RAM access occurs while rst is high.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_valid&cmd_ready latches addr and remaining = cmd_len.
  - Goes to WRITE if cmd_we=1, otherwise READ.
  - ram_en=0.
- WRITE:
  - wdata_ready=1.
  - Each cycle with wdata_valid=1: ram_en=1, ram_we=1, ram_din=wdata, ram_address=current addr (combinational from registered addr and wdata_valid).
  - After each beat: addr+1, remaining-1.
  - The beat with remaining==0 returns to IDLE next cycle.
  - wdata_valid=0 stalls with no RAM access.
- READ:
  - Issue condition: occupancy + inflight - pop < 2, where pop = rdata_valid&rdata_ready.
  - On issue: ram_en=1, ram_we=0, ram_address=addr; inflight set for the next cycle; addr+1, remaining-1.
  - Issue of the beat with remaining==0 moves to DRAIN.
  - Sustains 1 beat/cycle when rdata_ready is held high.
- Capture:
  - The cycle after an issue, ram_dout is pushed into the buffer with last = (beat was final).
  - ram_dout is never sampled on any other cycle; no-change mode holds stale data otherwise.
- DRAIN: no issues; returns to IDLE when inflight=0 and the buffer is empty (including the cycle the final pop occurs).
- Response buffer:
  - 2-entry FIFO. Push and pop in the same cycle are both honoured.
  - The issue rule guarantees no overflow.
  - rdata and rdata_last are stable while rdata_valid=1 and rdata_ready=0.
- Address arithmetic: modulo 2**addressWidth. A burst crossing the top address wraps to 0.
- Burst length: cmd_len = all-ones gives 2**lenWidth beats.
- cmd_ready=0 outside IDLE. Commands are never queued.

Test Plan:
- Write burst addr=3, len=3, data 0xA0..0xA3, wdata_valid always high: 4 consecutive ram_we cycles at addresses 3,4,5,6; cmd_ready returns 1 in the cycle after the 4th beat.
- Read burst addr=3, len=3, rdata_ready=1: rdata 0xA0..0xA3 on 4 consecutive cycles, the first 2 cycles after the command handshake; rdata_last only on 0xA3.
- Same read with rdata_ready low for 5 cycles after the first valid:
  - At most 2 reads issued during the stall.
  - rdata holds 0xA0.
  - No data lost or duplicated after release.
- Write addr=30, len=3 (addressWidth=5): RAM writes at 30,31,0,1; readback via read addr=30 len=3 returns the same order.
- Write with wdata_valid toggling 1,0,1,0,1: RAM writes only on valid cycles, total 3 beats for len=2; no ram_en on idle cycles.
- Assert rst in the cycle after the 2nd read issue:
  - All outputs at reset values immediately.
  - rdata_valid stays 0.
  - A subsequent read burst completes normally.

Source files
------------

// File: rtl/ram_nc_burst_initiator_if.sv
// Bus bundle between a burst client, the burst initiator and a no-change-mode
// single-port RAM. The "master" modport is the initiator's view (it accepts
// commands and drives the RAM port); "slave" is the environment's view
// (client plus RAM).
interface ram_nc_burst_initiator_if #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32,
  parameter int lenWidth     = 4
);
  // Command channel
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [addressWidth-1:0] cmd_addr;
  logic [lenWidth-1:0]     cmd_len;
  // Write data channel
  logic                    wdata_valid;
  logic                    wdata_ready;
  logic [dataWidth-1:0]    wdata;
  // Read data channel
  logic                    rdata_valid;
  logic                    rdata_ready;
  logic [dataWidth-1:0]    rdata;
  logic                    rdata_last;
  // Status
  logic                    busy;
  // RAM port
  logic                    ram_en;
  logic                    ram_we;
  logic [addressWidth-1:0] ram_address;
  logic [dataWidth-1:0]    ram_din;
  logic [dataWidth-1:0]    ram_dout;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  wdata_valid, wdata,
    input  rdata_ready,
    input  ram_dout,
    output cmd_ready, wdata_ready,
    output rdata_valid, rdata, rdata_last,
    output busy,
    output ram_en, ram_we, ram_address, ram_din
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    output wdata_valid, wdata,
    output rdata_ready,
    output ram_dout,
    input  cmd_ready, wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    input  busy,
    input  ram_en, ram_we, ram_address, ram_din
  );
endinterface

// File: rtl/ram_nc_burst_initiator.sv
// Burst initiator for a single-port, no-change-mode synchronous RAM.
// Converts client burst commands into one RAM access per cycle. Reads are
// issued only when the 2-entry response buffer is guaranteed to have room
// for the data returning one cycle later, so downstream backpressure never
// loses a beat and read throughput is one beat per cycle when unstalled.
module ram_nc_burst_initiator #(
  parameter int addressWidth = 5,
  parameter int dataWidth    = 32,
  parameter int lenWidth     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_nc_burst_initiator_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [addressWidth-1:0] AddrZero = {addressWidth{1'b0}};
  localparam logic [addressWidth-1:0] AddrOne  = {{(addressWidth-1){1'b0}}, 1'b1};
  localparam logic [lenWidth-1:0]     LenZero  = {lenWidth{1'b0}};
  localparam logic [lenWidth-1:0]     LenOne   = {{(lenWidth-1){1'b0}}, 1'b1};
  localparam logic [dataWidth-1:0]    DataZero = {dataWidth{1'b0}};

  // Sequencer state
  logic [1:0]              state_q, state_d;
  logic [addressWidth-1:0] addr_q, addr_d;
  logic [lenWidth-1:0]     remain_q, remain_d;

  // Read issued last cycle; its data is on ram_dout this cycle
  logic                    inflight_q, inflight_d;
  logic                    inflight_last_q, inflight_last_d;

  // Response buffer (2 entries)
  logic [dataWidth-1:0]    buf_data_q [2];
  logic [1:0]              buf_last_q;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              count_q, count_d;

  // Per-cycle decode
  logic                    last_beat_s;
  logic                    wr_beat_s;
  logic                    issue_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    buf_valid_s;
  logic [2:0]              occ_sum_s;
  logic [2:0]              occ_limit_s;

  assign last_beat_s = (remain_q == LenZero);
  assign buf_valid_s = (count_q != 2'd0);
  assign pop_s       = buf_valid_s & bus.rdata_ready;
  assign push_s      = inflight_q;
  assign wr_beat_s   = (state_q == StWrite) & bus.wdata_valid;

  // Read issue gate: buffered + in-flight - leaving must stay below 2 so the
  // beat returning next cycle always has a free slot.
  always_comb begin
    occ_sum_s   = {1'b0, count_q} + {2'b00, inflight_q};
    occ_limit_s = 3'd2 + {2'b00, pop_s};
    if (state_q == StRead) begin
      issue_s = (occ_sum_s < occ_limit_s);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state, address and beat-counter logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_addr;
          remain_d = bus.cmd_len;
          state_d  = bus.cmd_we ? StWrite : StRead;
        end else begin
          state_d  = StIdle;
        end
      end
      StWrite: begin
        if (bus.wdata_valid) begin
          addr_d   = addr_q + AddrOne;
          remain_d = remain_q - LenOne;
          state_d  = last_beat_s ? StIdle : StWrite;
        end else begin
          state_d  = StWrite;
        end
      end
      StRead: begin
        if (issue_s) begin
          addr_d   = addr_q + AddrOne;
          remain_d = remain_q - LenOne;
          state_d  = last_beat_s ? StDrain : StRead;
        end else begin
          state_d  = StRead;
        end
      end
      StDrain: begin
        // Leave once nothing is in flight and the buffer empties, counting a
        // pop of the final entry in this very cycle.
        if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop_s))) begin
          state_d = StIdle;
        end else begin
          state_d = StDrain;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // In-flight tracking for the one-cycle RAM read latency
  always_comb begin
    inflight_d = issue_s;
    if (issue_s) begin
      inflight_last_d = last_beat_s;
    end else begin
      inflight_last_d = 1'b0;
    end
  end

  // Response buffer pointer and occupancy update
  always_comb begin
    rd_ptr_d = pop_s  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Sequencer and tracking registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      addr_q          <= AddrZero;
      remain_q        <= LenZero;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
    end
  end

  // Response buffer storage; ram_dout is sampled only on the capture cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q[0] <= DataZero;
      buf_data_q[1] <= DataZero;
      buf_last_q    <= 2'b00;
    end else if (push_s) begin
      buf_data_q[wr_ptr_q] <= bus.ram_dout;
      buf_last_q[wr_ptr_q] <= inflight_last_q;
    end else begin
      buf_last_q <= buf_last_q;
    end
  end

  // Client-facing outputs
  always_comb begin
    bus.cmd_ready   = (state_q == StIdle);
    bus.wdata_ready = (state_q == StWrite);
    bus.busy        = (state_q != StIdle);
    bus.rdata_valid = buf_valid_s;
    bus.rdata       = buf_data_q[rd_ptr_q];
    bus.rdata_last  = buf_valid_s & buf_last_q[rd_ptr_q];
  end

  // RAM port: one access per write beat or read issue
  always_comb begin
    bus.ram_en      = wr_beat_s | issue_s;
    bus.ram_we      = wr_beat_s;
    bus.ram_address = addr_q;
    if (wr_beat_s) begin
      bus.ram_din = bus.wdata;
    end else begin
      bus.ram_din = DataZero;
    end
  end

endmodule

// File: tb/tb_ram_nc_burst_initiator.sv
// Directed bench for ram_nc_burst_initiator: client driver, no-change-mode
// RAM model and negedge monitors logging RAM accesses and accepted read beats.
module tb_ram_nc_burst_initiator;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   cyc;

  ram_nc_burst_initiator_if #(.addressWidth(5), .dataWidth(32), .lenWidth(4)) bus ();

  ram_nc_burst_initiator #(.addressWidth(5), .dataWidth(32), .lenWidth(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time-stamp monitored events
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // No-change-mode RAM model: dout only updates on reads
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_address] <= bus.ram_din;
      else            bus.ram_dout <= mem[bus.ram_address];
    end
  end

  // Monitors (sampled mid-cycle, away from the active edge)
  int          wr_cyc_q  [$];
  logic [4:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          rd_cyc_q  [$];
  logic [31:0] rd_data_q [$];
  logic        rd_last_q [$];
  int          en_cnt = 0;
  int          rd_iss = 0;
  always @(negedge clk) begin
    if (bus.ram_en) begin
      en_cnt = en_cnt + 1;
      if (bus.ram_we) begin
        wr_cyc_q.push_back(cyc);
        wr_addr_q.push_back(bus.ram_address);
        wr_data_q.push_back(bus.ram_din);
      end else begin
        rd_iss = rd_iss + 1;
      end
    end
    if (bus.rdata_valid && bus.rdata_ready) begin
      rd_cyc_q.push_back(cyc);
      rd_data_q.push_back(bus.rdata);
      rd_last_q.push_back(bus.rdata_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic we, input logic [4:0] a, input logic [3:0] l, output int hs);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("cmd_timeout", 32'd0, 32'd1);
    tick();
    hs = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] d);
    int n = 0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = d;
    @(negedge clk);
    while (!bus.wdata_ready && n < 20) begin n++; @(negedge clk); end
    if (n >= 20) check("wbeat_timeout", 32'd0, 32'd1);
    tick();
    bus.wdata_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [4:0] a, input logic [3:0] l, input logic [31:0] base,
                             input bit gaps, output int hs);
    issue_cmd(1'b1, a, l, hs);
    for (int i = 0; i <= int'(l); i++) begin
      push_beat(base + 32'(i));
      if (gaps && i < int'(l)) begin
        bus.wdata = 32'hDEAD_BEEF;
        tick();
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin n++; @(negedge clk); end
    check(tag, {31'd0, bus.busy}, 32'd0);
    tick();
  endtask

  // Check n read beats starting at log index b against base+i, last on final
  task automatic check_reads(input string tag, input int b, input int n, input logic [31:0] base);
    check({tag, "_count"}, 32'(rd_data_q.size() - b), 32'(n));
    for (int i = 0; i < n && (b + i) < rd_data_q.size(); i++) begin
      check({tag, "_data"}, rd_data_q[b+i], base + 32'(i));
      check({tag, "_last"}, {31'd0, rd_last_q[b+i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int hs, wb, rb, eb, ib;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = 5'd0; bus.cmd_len = 4'd0;
    bus.wdata_valid = 1'b0; bus.wdata = 32'd0; bus.rdata_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_ram_en",    {31'd0, bus.ram_en},    32'd0);
    check("rst_rvalid",    {31'd0, bus.rdata_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write burst addr 3, 4 beats, back to back
    wb = wr_addr_q.size();
    write_burst(5'd3, 4'd3, 32'hA0, 1'b0, hs);
    @(negedge clk);
    check("wr1_cmd_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    check("wr1_count", 32'(wr_addr_q.size() - wb), 32'd4);
    for (int i = 0; i < 4 && (wb + i) < wr_addr_q.size(); i++) begin
      check("wr1_addr", {27'd0, wr_addr_q[wb+i]}, 32'd3 + 32'(i));
      check("wr1_data", wr_data_q[wb+i], 32'hA0 + 32'(i));
      check("wr1_cycle", 32'(wr_cyc_q[wb+i]), 32'(hs + i));
    end
    tick();

    // Read burst addr 3, downstream always ready
    bus.rdata_ready = 1'b1;
    rb = rd_data_q.size();
    issue_cmd(1'b0, 5'd3, 4'd3, hs);
    wait_idle("rd1_done");
    check_reads("rd1", rb, 4, 32'hA0);
    for (int i = 0; i < 4 && (rb + i) < rd_cyc_q.size(); i++)
      check("rd1_cycle", 32'(rd_cyc_q[rb+i]), 32'(hs + 2 + i));

    // Same read with a 5-cycle downstream stall after the first valid
    bus.rdata_ready = 1'b0;
    rb = rd_data_q.size();
    ib = rd_iss;
    issue_cmd(1'b0, 5'd3, 4'd3, hs);
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.rdata_valid && n < 20) begin n++; @(negedge clk); end
      check("stall_first_valid", {31'd0, bus.rdata_valid}, 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      check("stall_hold_data", bus.rdata, 32'hA0);
      @(negedge clk);
    end
    check("stall_max_issues", {31'd0, (rd_iss - ib) <= 2}, 32'd1);
    tick();
    bus.rdata_ready = 1'b1;
    wait_idle("rd2_done");
    check_reads("rd2", rb, 4, 32'hA0);

    // Wrapping write at the top of the address space, then readback
    wb = wr_addr_q.size();
    write_burst(5'd30, 4'd3, 32'hB0, 1'b0, hs);
    check("wrap_count", 32'(wr_addr_q.size() - wb), 32'd4);
    for (int i = 0; i < 4 && (wb + i) < wr_addr_q.size(); i++)
      check("wrap_addr", {27'd0, wr_addr_q[wb+i]}, (i < 2) ? 32'd30 + 32'(i) : 32'(i - 2));
    tick();
    rb = rd_data_q.size();
    issue_cmd(1'b0, 5'd30, 4'd3, hs);
    wait_idle("wrap_rd_done");
    check_reads("wrap_rd", rb, 4, 32'hB0);

    // Write with wdata_valid toggling 1,0,1,0,1 (3 beats)
    wb = wr_addr_q.size();
    eb = en_cnt;
    write_burst(5'd10, 4'd2, 32'hC0, 1'b1, hs);
    @(negedge clk);
    check("gap_en_cycles", 32'(en_cnt - eb), 32'd3);
    check("gap_count", 32'(wr_addr_q.size() - wb), 32'd3);
    for (int i = 0; i < 3 && (wb + i) < wr_addr_q.size(); i++) begin
      check("gap_addr", {27'd0, wr_addr_q[wb+i]}, 32'd10 + 32'(i));
      check("gap_data", wr_data_q[wb+i], 32'hC0 + 32'(i));
    end
    tick();

    // Reset in the cycle after the second read issue
    bus.rdata_ready = 1'b0;
    ib = rd_iss;
    issue_cmd(1'b0, 5'd3, 4'd3, hs);
    tick();
    tick();
    check("rst_mid_issues_before", 32'(rd_iss - ib), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rstm_cmd_ready", {31'd0, bus.cmd_ready},   32'd1);
    check("rstm_wready",    {31'd0, bus.wdata_ready}, 32'd0);
    check("rstm_rvalid",    {31'd0, bus.rdata_valid}, 32'd0);
    check("rstm_rlast",     {31'd0, bus.rdata_last},  32'd0);
    check("rstm_busy",      {31'd0, bus.busy},        32'd0);
    check("rstm_ram_en",    {31'd0, bus.ram_en},      32'd0);
    check("rstm_ram_we",    {31'd0, bus.ram_we},      32'd0);
    check("rstm_ram_addr",  {27'd0, bus.ram_address}, 32'd0);
    check("rstm_ram_din",   bus.ram_din,              32'd0);
    eb = en_cnt;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rstm_no_access", 32'(en_cnt - eb), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rstm_rvalid_after", {31'd0, bus.rdata_valid}, 32'd0);
    check("rstm_idle_after",   {31'd0, bus.busy},        32'd0);
    tick();
    bus.rdata_ready = 1'b1;
    rb = rd_data_q.size();
    issue_cmd(1'b0, 5'd3, 4'd3, hs);
    wait_idle("post_rst_rd_done");
    check_reads("post_rst_rd", rb, 4, 32'hA0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time bound");
    $fatal(1);
  end

endmodule
